pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor to the fixed four-field EX/MEM latch. It carries NFIELDS packed DATA_W-bit fields (IR, PC4, ALU result, RT, …) between two CPU pipeline stages. A valid/ready handshake provides backpressure, flush inserts a NOP bubble, and an optional two-entry skid buffer registers the ready path. A saturating stall counter supports performance debugging.

## Interface
- DATA_W, 32: width of one field.
- NFIELDS, 4: number of packed fields; field k occupies bits [k*DATA_W +: DATA_W]; field 0 is the instruction (IR).
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears the block.
- in_valid  in  1  upstream stage has a beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  NFIELDS*DATA_W  packed upstream fields.
- flush  in  1  kill all held beats and replace them with a bubble.
- out_valid  out  1  out_data holds a real beat.
- out_ready  in  1  downstream stage consumes the beat.
- out_data  out  NFIELDS*DATA_W  packed fields; all zero (IR=0 is a NOP) when out_valid=0.
- occupancy  out  2  number of beats held (0..2; never exceeds 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Accept a beat when in_valid && in_ready. Emit a beat when out_valid && out_ready.
- Storage: main entry M drives out_data; skid entry S exists only when SKID=1.
- State machine (SKID=1):
  - EMPTY → ONE on accept.
  - ONE stays ONE on accept+emit (M←in) or on no activity.
  - ONE → EMPTY on emit without accept.
  - ONE → TWO on accept without emit (S←in).
  - TWO → ONE on emit (M←S). No accept is possible in TWO.
- in_ready (SKID=1) is a registered signal, equal to (next state ≠ TWO).
- SKID=0: in_ready = !out_valid || out_ready (combinational). M loads on accept. The states are EMPTY and ONE only.
- Flush has priority over everything:
  - Next state is EMPTY and M and S are zeroed.
  - A beat handshaken in the flush cycle is discarded.
  - An emit in the flush cycle still counts as consumed downstream.
- Fields are stored verbatim. There is no per-field logic and no data arithmetic.
- stall_cnt increments by 1 in each cycle with out_valid && !out_ready. It saturates at 2^CNT_W−1. Only reset clears it; flush does not.
- occupancy = 0/1/2 for EMPTY/ONE/TWO.

## Timing
- Reset values, forced for every cycle reset==0 is sampled:
  - out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=0 during reset; in_ready=1 from the first edge after reset returns to 1.
- Latency: a beat accepted at edge n appears on out_data/out_valid after edge n, when the block was EMPTY or emitted at edge n.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- SKID=1 backpressure:
  - out_ready falling is absorbed by S, so no beat is lost.
  - in_ready falls one edge after S fills.
  - in_ready rises one edge after S drains to M.
- Beat order is strict FIFO; S is never emitted before M.
- Mid-operation reset clears state exactly like flush and also clears stall_cnt.
- Flush and reset are both sampled only at clk edges; there are no asynchronous paths.

## Test plan
- Reset then stream (SKID=1, out_ready=1):
  - Stimulus: drive IR=0x2008_0005, PC4=0x3004, AO=5, RT=0, then three further beats with incrementing PC4.
  - Required response: each beat appears exactly 1 cycle later, in order, with out_valid=1; occupancy=1 throughout.
- Backpressure:
  - Stimulus: with M holding PC4=0x3004, drop out_ready for 3 cycles while in_valid=1 with PC4=0x3008.
  - Required response: S captures 0x3008; in_ready=0 from the next edge; occupancy=2; stall_cnt=3.
  - After out_ready returns: 0x3004 then 0x3008 are emitted, with no duplication and no loss.
- Flush in state TWO, with an incoming beat in the same cycle:
  - Required response: next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - The incoming beat never appears; stall_cnt is unchanged.
- SKID=0 pass-through:
  - Stimulus: out_ready=0 with M full.
  - Required response: in_ready=0 in the same cycle.
  - Stimulus: out_ready=1 with M full.
  - Required response: in_ready=1 in the same cycle, and accept+emit replace M back-to-back.
- Saturation:
  - Stimulus: CNT_W=4, stall for 20 cycles.
  - Required response: stall_cnt=15 and holds at 15.
- Mid-stream reset:
  - Stimulus: assert reset=0 for one edge while occupancy=2.
  - Required response: all outputs return to reset values; the next accepted beat is emitted normally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying NFIELDS packed fields with valid/ready backpressure,
// flush-to-bubble and an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NFIELDS = 4,
    parameter int unsigned SKID    = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NFIELDS*DATA_W-1:0] in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NFIELDS*DATA_W-1:0] out_data,
    output logic [1:0]                occupancy,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned W = NFIELDS * DATA_W;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     main_q, main_d;
    logic [W-1:0]     skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic accept;
    logic emit;

    assign out_valid = (state_q != StEmpty);
    // rdy_q is low for the cycle after reset; with SKID it also carries the registered ready
    assign in_ready  = (SKID != 0) ? rdy_q : (rdy_q && (!out_valid || out_ready));
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (emit) begin
                        // Clearing M keeps out_data a NOP bubble while empty
                        main_d  = '0;
                        state_d = StEmpty;
                    end else if (accept && (SKID != 0)) begin
                        skid_d  = in_data;
                        state_d = StTwo;
                    end
                end
                StTwo: begin
                    if (emit) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = StOne;
                    end
                end
                default: begin
                    main_d  = '0;
                    skid_d  = '0;
                    state_d = StEmpty;
                end
            endcase
        end

        rdy_d = (state_d != StTwo);
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            stall_q <= stall_d;
        end
    end

endmodule
